l1_pool_ctrl: RTL and testbench

Sequencer for the layer-1 2×2/stride-2 max-pool stage. It walks the L1 convolution output in buffer A (16×26×26 int8) and writes the pooled result to buffer B (16×13×13 int8). It drives the buffer A read-address port and the buffer B write port of the CNN RAM block directly. It sits between the L1 conv engine (producer of buffer A) and the L2 conv engine (consumer of buffer B), under the top-level inference FSM.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/l1_pool_ctrl_if.sv | 41 ++++
 rtl/pool_addr_gen.sv | 82 ++++++++
 rtl/l1_pool_ctrl.sv | 116 +++++++++++
 tb/tb_l1_pool_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN constants: layer-1 geometry, buffer address widths and the pool FSM state type.
package cnn_pkg;

    localparam int unsigned L1_CH       = 16;
    localparam int unsigned L1_DIM      = 26;
    localparam int unsigned L1_POOL_DIM = 13;

    localparam int unsigned BUF_A_AW = 14;
    localparam int unsigned BUF_B_AW = 12;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } pool_state_e;

endpackage

// File: rtl/l1_pool_ctrl_if.sv
// Pool controller bus: start/busy/done handshake, buffer A read port, buffer B write port.
// The master side is the pool controller; the slave side is the RAM block plus the inference FSM.
interface l1_pool_ctrl_if
    import cnn_pkg::*;
#(
    parameter int unsigned A_AW = BUF_A_AW,
    parameter int unsigned B_AW = BUF_B_AW
);

    logic            start;
    logic            busy;
    logic            done;
    logic [A_AW-1:0] buf_a_addr;
    logic [7:0]      buf_a_rd_data;
    logic [B_AW-1:0] buf_b_addr;
    logic [7:0]      buf_b_wr_data;
    logic            buf_b_wr_en;

    modport master (
        input  start,
        input  buf_a_rd_data,
        output busy,
        output done,
        output buf_a_addr,
        output buf_b_addr,
        output buf_b_wr_data,
        output buf_b_wr_en
    );

    modport slave (
        output start,
        output buf_a_rd_data,
        input  busy,
        input  done,
        input  buf_a_addr,
        input  buf_b_addr,
        input  buf_b_wr_data,
        input  buf_b_wr_en
    );

endinterface

// File: rtl/pool_addr_gen.sv
// Address generator for the 2x2/stride-2 pool walk. Keeps the window base in buffer A, the
// output column, the in-window tap index q and the buffer B write pointer. The window base is
// advanced incrementally so no multiplier is needed.
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int unsigned CH      = L1_CH,
    parameter int unsigned IN_DIM  = L1_DIM,
    parameter int unsigned OUT_DIM = IN_DIM / 2,
    parameter int unsigned A_AW    = BUF_A_AW,
    parameter int unsigned B_AW    = BUF_B_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,   // restart a pass from window 0
    input  logic            i_step,    // one READ cycle done: next tap
    input  logic            i_wrap,    // WRITE cycle done: next window
    output logic [A_AW-1:0] o_a_addr,
    output logic [B_AW-1:0] o_b_addr,
    output logic            o_q_first,
    output logic            o_q_last,
    output logic            o_last
);

    localparam int unsigned COL_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [A_AW-1:0]  A_STEP     = A_AW'(2);
    // Column wrap skips the odd input row of the window pair.
    localparam logic [A_AW-1:0]  A_ROW_STEP = A_AW'(IN_DIM + 2);
    localparam logic [A_AW-1:0]  OFF_RIGHT  = A_AW'(1);
    localparam logic [A_AW-1:0]  OFF_DOWN   = A_AW'(IN_DIM);
    localparam logic [A_AW-1:0]  OFF_DIAG   = A_AW'(IN_DIM + 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(OUT_DIM - 1);
    localparam logic [B_AW-1:0]  B_LAST     = B_AW'(CH * OUT_DIM * OUT_DIM - 1);

    logic [A_AW-1:0]  r_a_base;
    logic [COL_W-1:0] r_col;
    logic [1:0]       r_q;
    logic [B_AW-1:0]  r_b_ptr;
    logic [A_AW-1:0]  w_offset;

    // Counter state: cleared on reset or pass start, stepped by the FSM strobes.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_a_base <= '0;
            r_col    <= '0;
            r_q      <= '0;
            r_b_ptr  <= '0;
        end else if (i_wrap) begin
            r_q     <= '0;
            r_b_ptr <= r_b_ptr + B_AW'(1);
            if (r_col == COL_LAST) begin
                r_col    <= '0;
                r_a_base <= r_a_base + A_ROW_STEP;
            end else begin
                r_col    <= r_col + COL_W'(1);
                r_a_base <= r_a_base + A_STEP;
            end
        end else if (i_step) begin
            // 3 -> 0 roll-over is harmless: the FSM leaves READ after q=3.
            r_q <= r_q + 2'd1;
        end
    end

    // Tap offset within the 2x2 window: top-left, top-right, bottom-left, bottom-right.
    always_comb begin
        w_offset = '0;
        unique case (r_q)
            2'd0: w_offset = '0;
            2'd1: w_offset = OFF_RIGHT;
            2'd2: w_offset = OFF_DOWN;
            2'd3: w_offset = OFF_DIAG;
        endcase
    end

    assign o_a_addr  = r_a_base + w_offset;
    assign o_b_addr  = r_b_ptr;
    assign o_q_first = (r_q == 2'd0);
    assign o_q_last  = (r_q == 2'd3);
    assign o_last    = (r_b_ptr == B_LAST);

endmodule

// File: rtl/l1_pool_ctrl.sv
// Layer-1 max-pool sequencer: reads each 2x2 window of buffer A over four cycles, keeps the
// signed running maximum and writes it to buffer B in a fifth cycle.
module l1_pool_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned CH      = L1_CH,
    parameter int unsigned IN_DIM  = L1_DIM,
    parameter int unsigned OUT_DIM = IN_DIM / 2,
    parameter int unsigned A_AW    = BUF_A_AW,
    parameter int unsigned B_AW    = BUF_B_AW
) (
    input  logic           clk,
    input  logic           rst,
    l1_pool_ctrl_if.master bus
);

    if ((IN_DIM % 2) != 0) begin : g_in_dim_odd
        $error("l1_pool_ctrl: IN_DIM must be even");
    end

    pool_state_e     r_state;
    pool_state_e     w_state_next;
    logic [7:0]      r_mx;

    logic            w_clear;
    logic            w_step;
    logic            w_wrap;
    logic [A_AW-1:0] w_a_addr;
    logic [B_AW-1:0] w_b_addr;
    logic            w_q_first;
    logic            w_q_last;
    logic            w_last;

    pool_addr_gen #(
        .CH      (CH),
        .IN_DIM  (IN_DIM),
        .OUT_DIM (OUT_DIM),
        .A_AW    (A_AW),
        .B_AW    (B_AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_step    (w_step),
        .i_wrap    (w_wrap),
        .o_a_addr  (w_a_addr),
        .o_b_addr  (w_b_addr),
        .o_q_first (w_q_first),
        .o_q_last  (w_q_last),
        .o_last    (w_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Running signed maximum; q=0 loads unconditionally, ties keep the earlier value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mx <= '0;
        end else if (r_state == StRead) begin
            if (w_q_first || ($signed(bus.buf_a_rd_data) > $signed(r_mx))) begin
                r_mx <= bus.buf_a_rd_data;
            end
        end
    end

    // Next state and outputs; buses are held at zero outside the cycles that use them.
    always_comb begin
        w_state_next      = r_state;
        w_clear           = 1'b0;
        w_step            = 1'b0;
        w_wrap            = 1'b0;
        bus.busy          = 1'b0;
        bus.done          = 1'b0;
        bus.buf_a_addr    = '0;
        bus.buf_b_addr    = '0;
        bus.buf_b_wr_data = '0;
        bus.buf_b_wr_en   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_clear      = 1'b1;
                    w_state_next = StRead;
                end
            end
            StRead: begin
                bus.busy       = 1'b1;
                bus.buf_a_addr = w_a_addr;
                w_step         = 1'b1;
                if (w_q_last) begin
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                bus.busy          = 1'b1;
                bus.buf_b_wr_en   = 1'b1;
                bus.buf_b_wr_data = r_mx;
                bus.buf_b_addr    = w_b_addr;
                w_wrap            = 1'b1;
                w_state_next      = w_last ? StDone : StRead;
            end
            StDone: begin
                bus.done     = 1'b1;
                w_state_next = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_pool_ctrl.sv
// Scoreboard bench for l1_pool_ctrl: expected writes and done cycles are queued at start,
// a negedge monitor pops and compares them as the controller produces them.
module tb_l1_pool_ctrl;
    import cnn_pkg::*;

    localparam int N_OUT    = L1_CH * L1_POOL_DIM * L1_POOL_DIM;  // 2704
    localparam int A_SIZE   = 1 << BUF_A_AW;
    localparam int B_SIZE   = 1 << BUF_B_AW;
    localparam int PASS_CYC = 5 * N_OUT + 1;                      // done cycle after start edge

    typedef struct packed {
        logic [BUF_B_AW-1:0] addr;
        logic [7:0]          data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic [7:0] mem_a  [0:A_SIZE-1];
    logic [7:0] mem_b  [0:B_SIZE-1];
    logic [7:0] b_snap [0:N_OUT-1];

    wr_t exp_q[$];
    int  exp_done_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    int wr_count   = 0;
    int done_count = 0;

    l1_pool_ctrl_if #(.A_AW(BUF_A_AW), .B_AW(BUF_B_AW)) bus ();

    l1_pool_ctrl #(
        .CH      (L1_CH),
        .IN_DIM  (L1_DIM),
        .OUT_DIM (L1_POOL_DIM),
        .A_AW    (BUF_A_AW),
        .B_AW    (BUF_B_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.buf_a_rd_data = mem_a[bus.buf_a_addr];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference pooled value for output index n, computed from the window coordinates.
    function automatic logic [7:0] pool_ref(input int n);
        int c, r, x, base;
        logic signed [7:0] m;
        c    = n / (L1_POOL_DIM * L1_POOL_DIM);
        r    = (n % (L1_POOL_DIM * L1_POOL_DIM)) / L1_POOL_DIM;
        x    = n % L1_POOL_DIM;
        base = c * L1_DIM * L1_DIM + 2 * r * L1_DIM + 2 * x;
        m    = $signed(mem_a[base]);
        if ($signed(mem_a[base + 1]) > m)          m = $signed(mem_a[base + 1]);
        if ($signed(mem_a[base + L1_DIM]) > m)     m = $signed(mem_a[base + L1_DIM]);
        if ($signed(mem_a[base + L1_DIM + 1]) > m) m = $signed(mem_a[base + L1_DIM + 1]);
        return m;
    endfunction

    // Called on a negedge; start is sampled by the following posedge.
    task automatic do_start(output int k);
        wr_t e;
        k = cyc;
        for (int n = 0; n < N_OUT; n++) begin
            e.addr = BUF_B_AW'(n);
            e.data = pool_ref(n);
            exp_q.push_back(e);
        end
        exp_done_q.push_back(k + PASS_CYC);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    int'(bus.busy), 0);
        check({tag, "_done"},    int'(bus.done), 0);
        check({tag, "_wr_en"},   int'(bus.buf_b_wr_en), 0);
        check({tag, "_a_addr"},  int'(bus.buf_a_addr), 0);
        check({tag, "_b_addr"},  int'(bus.buf_b_addr), 0);
        check({tag, "_wr_data"}, int'(bus.buf_b_wr_data), 0);
    endtask

    task automatic fill_b();
        for (int i = 0; i < B_SIZE; i++) mem_b[i] = 8'h55;
    endtask

    // Monitor: every write and every done pulse is matched against the queued expectation.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.buf_b_wr_en === 1'b1) begin
            wr_count++;
            mem_b[bus.buf_b_addr] = bus.buf_b_wr_data;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(bus.buf_b_addr), int'(e.addr));
                check("wr_data", int'(bus.buf_b_wr_data), int'(e.data));
            end
        end
        if (bus.done === 1'b1) begin
            done_count++;
            if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
            else check("done_cycle", cyc, exp_done_q.pop_front());
        end
    end

    initial begin : driver
        int k, w0, d0, bad;
        bus.start = 1'b0;
        rst       = 1'b1;
        for (int a = 0; a < A_SIZE; a++) mem_a[a] = 8'(a % 128);
        fill_b();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Pass 1: address-mod-128 image, stray start mid-pass must be ignored.
        w0 = wr_count;
        d0 = done_count;
        do_start(k);
        wait_cyc(k + 500);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(k + PASS_CYC + 1);
        check("p1_b0",      int'(mem_b[0]),   27);
        check("p1_b12",     int'(mem_b[12]),  51);
        check("p1_b169",    int'(mem_b[169]), 63);
        check("p1_writes",  wr_count - w0,    N_OUT);
        check("p1_dones",   done_count - d0,  1);
        check("p1_idle",    int'(bus.busy),   0);

        // Pass 2: aborted by reset (with start held high alongside).
        for (int a = 0; a < A_SIZE; a++) mem_a[a] = 8'h80;
        mem_a[676 + 27] = 8'h81;
        fill_b();
        do_start(k);
        wait_cyc(k + 999);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_done_q.delete();
        w0 = wr_count;
        d0 = done_count;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        check("rst_start_busy", int'(bus.busy), 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_no_writes", wr_count - w0,   0);
        check("rst_no_done",   done_count - d0, 0);
        check("rst_idle_busy", int'(bus.busy),  0);

        // Pass 3: fresh pass on the all-0x80 image.
        w0 = wr_count;
        d0 = done_count;
        do_start(k);
        wait_cyc(k + PASS_CYC + 1);
        check("p3_b169", int'(mem_b[169]), 'h81);
        bad = 0;
        for (int i = 0; i < N_OUT; i++) if (i != 169 && mem_b[i] != 8'h80) bad++;
        check("p3_others_0x80", bad, 0);
        check("p3_writes", wr_count - w0,   N_OUT);
        check("p3_dones",  done_count - d0, 1);

        // Passes 4 and 5 back-to-back; window at B[5] holds {-1, 5, 0x7F, -128}.
        for (int a = 0; a < A_SIZE; a++) mem_a[a] = 8'(a % 128);
        mem_a[10] = 8'hFF;
        mem_a[11] = 8'h05;
        mem_a[36] = 8'h7F;
        mem_a[37] = 8'h80;
        fill_b();
        do_start(k);
        wait_cyc(k + PASS_CYC + 1);
        check("p4_b5", int'(mem_b[5]), 'h7F);
        for (int i = 0; i < N_OUT; i++) b_snap[i] = mem_b[i];
        fill_b();
        w0 = wr_count;
        d0 = done_count;
        do_start(k);
        wait_cyc(k + PASS_CYC + 1);
        bad = 0;
        for (int i = 0; i < N_OUT; i++) if (mem_b[i] != b_snap[i]) bad++;
        check("p5_same_as_p4", bad, 0);
        check("p5_writes", wr_count - w0,   N_OUT);
        check("p5_dones",  done_count - d0, 1);

        repeat (5) @(negedge clk);
        check("exp_writes_left", exp_q.size(),      0);
        check("exp_dones_left",  exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
